// File: rtl/reg_alu_pkg.sv
// Shared types, ALU function codes and instruction field positions for the
// register-file/ALU instruction sequencer.
package reg_alu_pkg;

  typedef enum logic [1:0] {
    CLS_RR  = 2'b00,
    CLS_RI  = 2'b01,
    CLS_REP = 2'b10,
    CLS_RSV = 2'b11
  } cls_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  localparam int CLS_MSB = 15;
  localparam int CLS_LSB = 14;
  localparam int FN_MSB  = 13;
  localparam int FN_LSB  = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 8;
  localparam int RS1_MSB = 7;
  localparam int RS1_LSB = 4;
  localparam int RS2_MSB = 3;
  localparam int RS2_LSB = 0;

  function automatic cls_e instr_cls(input logic [15:0] ins);
    return cls_e'(ins[CLS_MSB:CLS_LSB]);
  endfunction

endpackage

// File: rtl/reg_alu_seq_decode.sv
// Combinational datapath control decode from the latched instruction and the
// sequencer state.
module reg_alu_seq_decode
  import reg_alu_pkg::*;
(
  input  logic [15:0] instr_q_i,
  input  state_e      state_i,
  output logic [3:0]  ra1_o,
  output logic [3:0]  ra2_o,
  output logic [3:0]  wa_o,
  output logic        alu_src_o,
  output logic [1:0]  alu_ctrl_o,
  output logic        reg_write_o
);

  cls_e       cls;
  logic [3:0] rd;
  logic [3:0] rs1;
  logic [3:0] rs2;

  assign cls = instr_cls(instr_q_i);
  assign rd  = instr_q_i[RD_MSB:RD_LSB];
  assign rs1 = instr_q_i[RS1_MSB:RS1_LSB];
  assign rs2 = instr_q_i[RS2_MSB:RS2_LSB];

  always_comb begin
    ra1_o       = rs1;
    ra2_o       = rs2;
    wa_o        = rd;
    alu_src_o   = 1'b0;
    alu_ctrl_o  = instr_q_i[FN_MSB:FN_LSB];
    reg_write_o = 1'b0;

    case (cls)
      CLS_RI:  alu_src_o = 1'b1;
      // Accumulate form reads the destination back as the first operand.
      CLS_REP: begin
        ra1_o = rd;
        ra2_o = rs1;
      end
      default: ;
    endcase

    if ((state_i == ST_EXEC) && (cls != CLS_RSV)) begin
      reg_write_o = 1'b1;
    end
  end

endmodule

// File: rtl/reg_alu_sequencer.sv
// Multi-cycle instruction sequencer: accepts one instruction over valid/ready,
// steps the register-file/ALU datapath and reports completion with the result.
//
// state   | meaning
// IDLE    | ready for an instruction
// EXEC    | one datapath write per cycle; REP loops here until count expires
// DONE    | done (and err for reserved class) asserted for one cycle
module reg_alu_sequencer
  import reg_alu_pkg::*;
#(
  parameter int REP_W = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_valid,
  input  logic [15:0] instr,
  input  logic [7:0]  instr_imm,
  output logic        instr_ready,
  output logic [3:0]  RA1,
  output logic [3:0]  RA2,
  output logic [3:0]  WA,
  output logic        RegWrite,
  output logic        ALUSrc,
  output logic [1:0]  ALUControl,
  output logic [7:0]  external_data_in,
  input  logic [7:0]  ALUResult,
  output logic        done,
  output logic [7:0]  result,
  output logic        err,
  output logic        busy
);

  state_e             state_q, state_d;
  logic [15:0]        instr_q, instr_d;
  logic [7:0]         imm_q, imm_d;
  logic [REP_W-1:0]   cnt_q, cnt_d;
  logic [7:0]         result_q, result_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  cls_e               cls_in;
  cls_e               cls_q;
  logic [3:0]         rep_in;

  assign cls_in = instr_cls(instr);
  assign cls_q  = instr_cls(instr_q);
  assign rep_in = instr[RS2_MSB:RS2_LSB];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      instr_q  <= '0;
      imm_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      instr_q  <= instr_d;
      imm_q    <= imm_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    instr_d  = instr_q;
    imm_d    = imm_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    done_d   = 1'b0;
    err_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (instr_valid) begin
          instr_d = instr;
          imm_d   = instr_imm;
          cnt_d   = REP_W'(rep_in);
          // Nothing to write: go straight to the completion cycle.
          if ((cls_in == CLS_RSV) || ((cls_in == CLS_REP) && (rep_in == 4'd0))) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            err_d   = (cls_in == CLS_RSV);
          end else begin
            state_d = ST_EXEC;
          end
        end
      end
      ST_EXEC: begin
        result_d = ALUResult;
        if (cls_q == CLS_REP) begin
          cnt_d = cnt_q - REP_W'(1);
        end
        if ((cls_q == CLS_REP) && (cnt_q != REP_W'(1))) begin
          state_d = ST_EXEC;
        end else begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  reg_alu_seq_decode u_decode (
    .instr_q_i   (instr_q),
    .state_i     (state_q),
    .ra1_o       (RA1),
    .ra2_o       (RA2),
    .wa_o        (WA),
    .alu_src_o   (ALUSrc),
    .alu_ctrl_o  (ALUControl),
    .reg_write_o (RegWrite)
  );

  assign instr_ready      = (state_q == ST_IDLE);
  assign busy             = (state_q != ST_IDLE);
  assign external_data_in = imm_q;
  assign done             = done_q;
  assign err              = err_q;
  assign result           = result_q;

endmodule

// File: tb/tb_reg_alu_sequencer.sv
// Scoreboard bench: sequencer driving a behavioural register file and ALU.
module tb_reg_alu_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_valid;
  logic [15:0] instr;
  logic [7:0]  instr_imm;
  logic        instr_ready;
  logic [3:0]  RA1, RA2, WA;
  logic        RegWrite;
  logic        ALUSrc;
  logic [1:0]  ALUControl;
  logic [7:0]  external_data_in;
  logic [7:0]  ALUResult;
  logic        done;
  logic [7:0]  result;
  logic        err;
  logic        busy;

  always #5 clk = ~clk;

  reg_alu_sequencer #(.REP_W(4)) dut (
    .clk              (clk),
    .reset            (reset),
    .instr_valid      (instr_valid),
    .instr            (instr),
    .instr_imm        (instr_imm),
    .instr_ready      (instr_ready),
    .RA1              (RA1),
    .RA2              (RA2),
    .WA               (WA),
    .RegWrite         (RegWrite),
    .ALUSrc           (ALUSrc),
    .ALUControl       (ALUControl),
    .external_data_in (external_data_in),
    .ALUResult        (ALUResult),
    .done             (done),
    .result           (result),
    .err              (err),
    .busy             (busy)
  );

  // Datapath: register file with combinational read, write at the edge.
  logic [7:0] rf [16];
  logic       rf_clr;
  logic [7:0] alu_a, alu_b;

  assign alu_a = rf[RA1];
  assign alu_b = ALUSrc ? external_data_in : rf[RA2];

  always_comb begin
    ALUResult = 8'h00;
    case (ALUControl)
      2'b00: ALUResult = alu_a + alu_b;
      2'b01: ALUResult = alu_a - alu_b;
      2'b10: ALUResult = alu_a & alu_b;
      2'b11: ALUResult = alu_a | alu_b;
      default: ALUResult = 8'h00;
    endcase
  end

  always @(posedge clk) begin
    if (rf_clr) begin
      for (int i = 0; i < 16; i++) rf[i] <= 8'h00;
    end else if (RegWrite) begin
      rf[WA] <= ALUResult;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] res;
    logic       err;
    int         cyc;
    int         nwr;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   wr_cnt  = 0;
  int   last_acc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Monitor: pops one expectation per done pulse.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      wr_cnt = 0;
    end else begin
      if (RegWrite) wr_cnt++;
      if (err && !done) check("err_without_done", {31'd0, err}, 32'd0);
      if (done) begin
        if (sb_q.size() == 0) begin
          check("unexpected_done", {31'd0, done}, 32'd0);
        end else begin
          e = sb_q.pop_front();
          check("result", {24'd0, result}, {24'd0, e.res});
          check("err", {31'd0, err}, {31'd0, e.err});
          check("done_cycle", cyc, e.cyc);
          check("write_count", wr_cnt, e.nwr);
        end
        wr_cnt = 0;
      end
    end
  end

  // lat: cycles from the accepting edge to the done cycle (RR/RI 2, REP N+1, N=0/rsv 1).
  task automatic issue(input logic [15:0] ins, input logic [7:0] imm, input logic [7:0] eres,
                       input logic eerr, input int lat, input int nwr, input bit keep_valid);
    exp_t e;
    int   t;
    @(negedge clk);
    instr       = ins;
    instr_imm   = imm;
    instr_valid = 1'b1;
    t = 0;
    while (!instr_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!instr_ready) begin
      check("accept_timeout", {31'd0, instr_ready}, 32'd1);
    end else begin
      last_acc = cyc + 1;
      e.res = eres;
      e.err = eerr;
      e.cyc = cyc + lat;
      e.nwr = nwr;
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
    if (!keep_valid) instr_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int acc0, acc1, acc2;
    int t;
    reset       = 1'b1;
    rf_clr      = 1'b1;
    instr_valid = 1'b0;
    instr       = 16'h0000;
    instr_imm   = 8'h00;
    repeat (3) @(negedge clk);
    reset  = 1'b0;
    rf_clr = 1'b0;
    @(negedge clk);
    check("rst_ready", {31'd0, instr_ready}, 32'd1);
    check("rst_regwrite", {31'd0, RegWrite}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_result", {24'd0, result}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);

    issue(16'h4100, 8'h05, 8'h05, 1'b0, 2, 1, 1'b0);  // RI  r1 = r0 + 5
    issue(16'h8213, 8'h00, 8'h0F, 1'b0, 4, 3, 1'b0);  // REP r2 += r1 x3
    issue(16'h1321, 8'h00, 8'h0A, 1'b0, 2, 1, 1'b0);  // RR  r3 = r2 - r1
    issue(16'h3431, 8'h00, 8'h0F, 1'b0, 2, 1, 1'b0);  // RR  r4 = r3 | r1
    issue(16'h8210, 8'h00, 8'h0F, 1'b0, 1, 0, 1'b0);  // REP N=0
    issue(16'hC000, 8'h00, 8'h0F, 1'b1, 1, 0, 1'b0);  // reserved

    // Valid held high across three RR instructions.
    issue(16'h0512, 8'h00, 8'h14, 1'b0, 2, 1, 1'b1);  // r5 = r1 + r2
    acc0 = last_acc;
    issue(16'h2634, 8'h00, 8'h0A, 1'b0, 2, 1, 1'b1);  // r6 = r3 & r4
    acc1 = last_acc;
    issue(16'h1752, 8'h00, 8'h05, 1'b0, 2, 1, 1'b0);  // r7 = r5 - r2
    acc2 = last_acc;
    check("throughput_1", acc1 - acc0, 32'd3);
    check("throughput_2", acc2 - acc1, 32'd3);

    t = 0;
    while (sb_q.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("drain", sb_q.size(), 32'd0);
    check("r7_value", {24'd0, rf[7]}, 32'h05);

    // Reset during the second iteration of REP N=8 (r2 = 15 before).
    @(negedge clk);
    instr       = 16'h8218;
    instr_imm   = 8'h00;
    instr_valid = 1'b1;
    t = 0;
    while (!instr_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("rep8_ready", {31'd0, instr_ready}, 32'd1);
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    @(negedge clk);
    check("rep8_iter1_write", {31'd0, RegWrite}, 32'd1);
    @(negedge clk);
    check("rep8_iter2_write", {31'd0, RegWrite}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rep8_rst_ready", {31'd0, instr_ready}, 32'd1);
    check("rep8_rst_regwrite", {31'd0, RegWrite}, 32'd0);
    check("rep8_rst_result", {24'd0, result}, 32'd0);
    check("rep8_r2", {24'd0, rf[2]}, 32'h19);
    repeat (3) begin
      @(negedge clk);
      check("rep8_no_more_write", {31'd0, RegWrite}, 32'd0);
    end
    check("rep8_r2_final", {24'd0, rf[2]}, 32'h19);
    check("final_queue", sb_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_alu_sequencer.md
# reg_alu_sequencer

Multi-cycle instruction sequencer for the register-file/ALU datapath. Accepts one 16-bit instruction at a time over a valid/ready handshake, drives the datapath controls (read/write addresses, `RegWrite`, `ALUSrc`, `ALUControl`, immediate operand), and reports completion with the final ALU result. Supports register-register, register-immediate and repeated-accumulate operations, for example multiply by repeated add. Sits between the instruction source (test harness or front-end) and the datapath.

## Interface
Parameters:
- `REP_W`, default 4: width of the repeat count field.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `instr_valid` in 1: instruction and immediate are presented.
- `instr` in 16: instruction word.
- `instr_imm` in 8: immediate operand, sampled with `instr`.
- `instr_ready` out 1: high only in IDLE.
- `RA1`, `RA2`, `WA` out 4 each: datapath register addresses.
- `RegWrite` out 1: datapath write enable.
- `ALUSrc` out 1: 0 selects RD2, 1 selects `external_data_in`.
- `ALUControl` out 2: ALU function.
- `external_data_in` out 8: latched immediate.
- `ALUResult` in 8: datapath result, fed back.
- `done` out 1: one-cycle completion pulse.
- `result` out 8: last written value.
- `err` out 1: one-cycle pulse for a reserved class.
- `busy` out 1: state ≠ IDLE.

## Operation
Instruction fields:
- [15:14] class: 00 RR, 01 RI, 10 REP, 11 reserved.
- [13:12] fn, driven directly onto `ALUControl`: 00 add, 01 sub, 10 and, 11 or.
- [11:8] rd, [7:4] rs1, [3:0] rs2 or rep count.

Class behaviour:
- RR: rd ← rs1 fn rs2. RA1=rs1, RA2=rs2, WA=rd, ALUSrc=0.
- RI: rd ← rs1 fn imm. RA1=rs1, WA=rd, ALUSrc=1, `external_data_in`=imm.
- REP: rd ← rd fn rs1, repeated N=[3:0] times. RA1=rd, RA2=rs1, WA=rd, ALUSrc=0. N=0 performs no write.
- Reserved: no write; `err` pulses together with `done`.

State machine, states IDLE, EXEC, DONE:
- IDLE: on `instr_valid` && `instr_ready`, latch `instr`, `instr_imm` and count → EXEC. Reserved class or REP with N=0 → DONE.
- EXEC: `RegWrite`=1 for exactly this cycle. Capture `ALUResult` into `result` at the edge. RR/RI → DONE. REP decrements count and stays in EXEC while count after decrement ≠ 0, otherwise → DONE.
- DONE: `done`=1 for one cycle → IDLE.

Output rules:
- Control outputs are decoded combinationally from the latched instruction and the state.
- Outside EXEC: `RegWrite`=0, and addresses and controls hold their latched values (don't-care to the datapath).
- REP relies on the register file writing at the edge with combinational read, so each iteration sees the previous write.
- `result` on N=0 or reserved is unchanged from its prior value.

Reset:
- All registered outputs clear to 0: `result`, latched fields, count, `done`, `err`. With those fields cleared, `RegWrite`=0, `ALUSrc`=0, `ALUControl`=00, RA1/RA2/WA=0, `external_data_in`=0.
- State returns to IDLE, so `instr_ready`=1 in the first cycle after reset deasserts.
- Reset in EXEC takes priority over the write's successor state. The write in progress during that cycle still occurs; no further writes occur.

## Timing
- Instruction accepted at edge k.
- RR/RI: EXEC in cycle k+1, write at edge k+2, `done`/`result` valid in cycle k+2, `instr_ready` high in cycle k+3.
- REP N≥1: EXEC in cycles k+1..k+N, `done` in cycle k+N+1.
- REP N=0 or reserved: `done` (and `err`) in cycle k+1.
- Back-to-back: the next instruction is accepted no earlier than the edge ending the first IDLE cycle after DONE. Throughput for RR/RI is 3 cycles per instruction.
- `instr_valid` held while not ready is not consumed. Instructions need not be held after acceptance.

## Structure
- Package `reg_alu_pkg`:
  - class enum (RR, RI, REP, RSV)
  - state enum (IDLE, EXEC, DONE)
  - ALU fn localparams (ADD, SUB, AND, OR)
  - instruction field bit positions
- One sub-module, `reg_alu_seq_decode`: combinational mapping from latched instruction plus state to RA1/RA2/WA/ALUSrc/`ALUControl`/`RegWrite`.
- Top level holds the FSM, latches and repeat counter.
- Bench instantiates this block with the existing register-file/ALU datapath. The register file resets to all zero.

## Test plan
- After reset: `instr_ready`=1, `RegWrite`=0, `done`=0, `result`=0.
- RI add rd=1, rs1=0, imm=5 (instr 0x4100, imm 0x05) → one `RegWrite` cycle, `done` at k+2, `result`=5.
- Then REP add rd=2, rs1=1, N=3 (0x8213) → exactly 3 `RegWrite` cycles, `result`=15, `done` at k+4.
- RR sub rd=3, rs1=2, rs2=1 (0x1321) → `result`=10.
- RR or rd=4, rs1=3, rs2=1 (0x3431) → `result`=0x0F.
- REP N=0 (0x8210) → no `RegWrite`, `done` at k+1, `result` unchanged. Reserved class (0xC000) → `err` and `done` in the same cycle, no write.
- `instr_valid` held high continuously → accepts occur exactly every 3 cycles.
- `reset` asserted mid-REP (N=8, after 2 iterations) → IDLE next cycle, `instr_ready`=1, r2 reflects only the completed writes.
